// File: rtl/weather_tx_scheduler.sv
// weather_tx_scheduler: round-robin framer serialising 3-bit sensor codes MSB first onto x.
// Define WEATHER_PARITY_EN to append an even-parity bit (PAR state) after each code.
module weather_tx_scheduler (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       en,
    input  logic [2:0] req,
    input  logic [2:0] code_t,
    input  logic [2:0] code_h,
    input  logic [2:0] code_w,
    output logic       x,
    output logic [2:0] ack,
    output logic       busy,
    output logic [1:0] sensor_id,
    output logic [7:0] frame_cnt
);
`ifdef WEATHER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif
    state_t state, state_n;
    logic [1:0] ptr, ptr_n, cnt, cnt_n, sid_n, g, p1, p2;
    logic [2:0] code, code_n, ack_n;
    logic [7:0] fcnt_n;
    logic x_n;
    logic hold;  // suppresses a grant on the first edge after reset is released
    assign busy = state != IDLE;
    assign p1 = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
    assign p2 = ptr == 2'd0 ? 2'd2 : ptr - 2'd1;
    assign g = req[ptr] ? ptr : req[p1] ? p1 : p2;
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            ptr <= 2'd0;
            cnt <= 2'd0;
            code <= 3'b000;
            x <= 1'b0;
            ack <= 3'b000;
            sensor_id <= 2'd3;
            frame_cnt <= 8'd0;
            hold <= 1'b1;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            code <= code_n;
            x <= x_n;
            ack <= ack_n;
            sensor_id <= sid_n;
            frame_cnt <= fcnt_n;
            hold <= 1'b0;
        end
    end
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        cnt_n = cnt;
        code_n = code;
        x_n = 1'b0;
        ack_n = 3'b000;
        sid_n = sensor_id;
        fcnt_n = frame_cnt;
        case (state)
            IDLE: if (en && req != 3'b000 && !hold) begin
                state_n = SEND;
                ptr_n = g == 2'd2 ? 2'd0 : g + 2'd1;
                cnt_n = 2'd0;
                code_n = g == 2'd0 ? code_t : g == 2'd1 ? code_h : code_w;
                x_n = code_n[2];
                ack_n = 3'b001 << g;
                sid_n = g;
            end
            SEND: begin
                cnt_n = cnt + 2'd1;
                x_n = cnt == 2'd0 ? code[1] : code[0];
                if (cnt == 2'd2) begin
                    cnt_n = 2'd0;
`ifdef WEATHER_PARITY_EN
                    state_n = PAR;
                    x_n = ^code;
`else
                    state_n = GAP;
                    x_n = 1'b0;
`endif
                end
            end
`ifdef WEATHER_PARITY_EN
            PAR: state_n = GAP;
`endif
            GAP: begin
                cnt_n = cnt + 2'd1;
                if (cnt == 2'd1) begin
                    state_n = IDLE;
                    cnt_n = 2'd0;
                    sid_n = 2'd3;
                    fcnt_n = frame_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_weather_tx_scheduler.sv
// tb_weather_tx_scheduler: directed stimulus with a scoreboard queue of expected frames;
// a negedge monitor pops an entry on every ack pulse and checks ack, sensor_id, period and x bits.
module tb_weather_tx_scheduler;
`ifdef WEATHER_PARITY_EN
    localparam int P = 7;
`else
    localparam int P = 6;
`endif
    localparam int L = P - 1;

    typedef struct {
        logic [2:0] ack;
        logic [1:0] sid;
        logic [5:0] bits;
        int         gap;
    } exp_t;

    logic       CLK = 1'b0, Reset = 1'b1, en = 1'b0, x, busy;
    logic [2:0] req = 3'b000, code_t = 3'b000, code_h = 3'b000, code_w = 3'b000, ack;
    logic [1:0] sensor_id;
    logic [7:0] frame_cnt;

    exp_t q[$];
    exp_t cur;
    logic col = 1'b0;
    int   idx = 0, cyc = 0, last_ack = 0, n_cmp = 0, n_err = 0;

    weather_tx_scheduler dut (
        .CLK(CLK), .Reset(Reset), .en(en), .req(req),
        .code_t(code_t), .code_h(code_h), .code_w(code_w),
        .x(x), .ack(ack), .busy(busy), .sensor_id(sensor_id), .frame_cnt(frame_cnt)
    );

    initial forever #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(string n, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic exp_t mk(int gi, logic [2:0] c, int gap);
        exp_t e;
        e.ack = 3'b001 << gi;
        e.sid = 2'(gi);
`ifdef WEATHER_PARITY_EN
        e.bits = {c, ^c, 2'b00};
`else
        e.bits = {c, 3'b000};
`endif
        e.gap = gap;
        return e;
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        en = 1'b0;
        req = 3'b000;
        tick();
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (ack != 3'b000) begin
                chk("ack_overlap", int'(col), 0);
                if (q.size() == 0) chk("ack_unexpected", int'(ack), 0);
                else begin
                    cur = q.pop_front();
                    chk("ack", int'(ack), int'(cur.ack));
                    chk("sensor_id", int'(sensor_id), int'(cur.sid));
                    if (cur.gap != 0) chk("period", cyc - last_ack, cur.gap);
                    col = 1'b1;
                    idx = 0;
                end
                last_ack = cyc;
            end
            if (col) begin
                chk("x_bit", int'(x), int'(cur.bits[5 - idx]));
                idx++;
                if (idx == L) col = 1'b0;
            end else chk("x_idle", int'(x), 0);
            if (Reset) col = 1'b0;
        end
    end

    initial begin
        // reset held two edges, then single temperature frame
        tick();
        tick();
        chk("rst_x", int'(x), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sid", int'(sensor_id), 3);
        chk("rst_fcnt", int'(frame_cnt), 0);
        req = 3'b001; code_t = 3'b111; en = 1'b1; Reset = 1'b0;
        q.push_back(mk(0, 3'b111, 0));
        tick();
        chk("no_grant_after_rst", int'(busy), 0);
        tick();
        chk("grant_busy", int'(busy), 1);
        req = 3'b000; code_t = 3'b000;
        repeat (L) tick();
        chk("t1_fcnt", int'(frame_cnt), 1);
        chk("t1_sid_idle", int'(sensor_id), 3);

        // all three requesting: t, h, w, t back to back
        do_reset();
        code_t = 3'b111; code_h = 3'b010; code_w = 3'b101; req = 3'b111; en = 1'b1; Reset = 1'b0;
        q.push_back(mk(0, 3'b111, 0));
        q.push_back(mk(1, 3'b010, P));
        q.push_back(mk(2, 3'b101, P));
        q.push_back(mk(0, 3'b111, P));
        tick();
        repeat (1 + 3 * P) tick();
        req = 3'b000;
        repeat (L) tick();
        chk("t2_fcnt", int'(frame_cnt), 4);
        chk("t2_busy", int'(busy), 0);

        // temperature idle while holding the pointer
        do_reset();
        req = 3'b110; en = 1'b1; Reset = 1'b0;
        q.push_back(mk(1, 3'b010, 0));
        q.push_back(mk(2, 3'b101, P));
        tick();
        repeat (1 + P) tick();
        req = 3'b000;
        repeat (L) tick();
        chk("t3_fcnt", int'(frame_cnt), 2);

        // reset in the second SEND cycle aborts the frame
        do_reset();
        code_t = 3'b101; req = 3'b001; en = 1'b1; Reset = 1'b0;
        q.push_back(mk(0, 3'b101, 0));
        tick();
        tick();
        req = 3'b000;
        tick();
        Reset = 1'b1;
        tick();
        chk("abort_x", int'(x), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_fcnt", int'(frame_cnt), 0);
        chk("abort_sid", int'(sensor_id), 3);
        req = 3'b011; Reset = 1'b0;
        q.push_back(mk(0, 3'b101, 0));
        tick();
        tick();
        req = 3'b000;
        repeat (L) tick();
        chk("t4_fcnt", int'(frame_cnt), 1);

        // en dropped mid-frame
        do_reset();
        code_t = 3'b111; req = 3'b111; en = 1'b1; Reset = 1'b0;
        q.push_back(mk(0, 3'b111, 0));
        tick();
        tick();
        tick();
        en = 1'b0;
        repeat (P) tick();
        chk("t5_busy", int'(busy), 0);
        chk("t5_fcnt", int'(frame_cnt), 1);
        repeat (5) tick();
        chk("t5_busy_held", int'(busy), 0);
        en = 1'b1;
        q.push_back(mk(1, 3'b010, 0));
        tick();
        chk("t5_regrant", int'(busy), 1);
        req = 3'b000;
        repeat (L) tick();
        chk("t5_fcnt2", int'(frame_cnt), 2);

        // 256 back-to-back frames wrap frame_cnt
        do_reset();
        code_t = 3'b111; req = 3'b001; en = 1'b1; Reset = 1'b0;
        q.push_back(mk(0, 3'b111, 0));
        for (int i = 1; i < 256; i++) q.push_back(mk(0, 3'b111, P));
        tick();
        repeat (255 * P) tick();
        chk("wrap_255", int'(frame_cnt), 255);
        tick();
        req = 3'b000;
        repeat (L) tick();
        chk("wrap_0", int'(frame_cnt), 0);

        // code 110 (parity bit 0 when enabled)
        do_reset();
        code_t = 3'b110; req = 3'b001; en = 1'b1; Reset = 1'b0;
        q.push_back(mk(0, 3'b110, 0));
        tick();
        tick();
        req = 3'b000;
        repeat (L) tick();
        chk("t7_fcnt", int'(frame_cnt), 1);

        repeat (3) tick();
        chk("sb_empty", q.size(), 0);
        chk("sb_idle", int'(col), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
